// File: rtl/game_pkg.sv
// Shared definitions for the target game: state encoding, target count and index folding.
// Helpers are pure functions; no storage lives here.
package game_pkg;

    localparam int NUM_TARGETS = 18;
    localparam int IDX_W       = 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PICK,
        SHOW,
        DONE
    } state_t;

    // A 5-bit raw value spans 0..31; values 18..31 are folded down by one target count.
    function automatic logic [IDX_W-1:0] fold_idx(input logic [IDX_W-1:0] raw);
        return (raw < IDX_W'(NUM_TARGETS)) ? raw : raw - IDX_W'(NUM_TARGETS);
    endfunction

endpackage

// File: rtl/target_decode.sv
// Folds a raw 5-bit random value into a target index and decodes it one-hot.
// Latency: combinational. Backpressure: none.
module target_decode
    import game_pkg::*;
(
    input  logic [IDX_W-1:0]       raw_idx,
    output logic [NUM_TARGETS-1:0] onehot
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        idx    = fold_idx(raw_idx);
        onehot = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/target_picker.sv
// Round sequencer: requests a random number, lights one target, scores hit or timeout miss.
// Latency: start to lit target RNG_WAIT+2 cycles; no stall path, start is a level. NO_REPEAT_EN rejects repeats.
module target_picker
    import game_pkg::*;
#(
    parameter int RNG_WAIT = 2,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_TARGETS-1:0] random_value,
    input  logic [NUM_TARGETS-1:0] hit_sw,
    output logic                   change,
    output logic [NUM_TARGETS-1:0] target,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [7:0]             round_cnt
);

    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam int WAIT_W = (RNG_WAIT > 2) ? $clog2(RNG_WAIT - 1) : 1;
    // The PICK cycle itself is the last wait cycle, so WAIT lasts RNG_WAIT-1 cycles.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RNG_WAIT > 1) ? RNG_WAIT - 2 : 0);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    state_t                   state;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [TMR_W-1:0]         timer;
    logic [NUM_TARGETS-1:0]   pick_onehot;
    logic                     unused_rng_bits;
`ifdef NO_REPEAT_EN
    logic [NUM_TARGETS-1:0]   prev_onehot;
`endif

    assign unused_rng_bits = ^random_value[NUM_TARGETS-1:IDX_W];

    target_decode u_decode (
        .raw_idx (random_value[IDX_W-1:0]),
        .onehot  (pick_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            timer       <= '0;
            change      <= 1'b0;
            target      <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            round_cnt   <= '0;
`ifdef NO_REPEAT_EN
            prev_onehot <= '0;
`endif
        end else begin
            change     <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= REQ;
                        change <= 1'b1;
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= (RNG_WAIT == 1) ? PICK : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= PICK;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                PICK: begin
`ifdef NO_REPEAT_EN
                    // Stored one-hot; zero after reset so the first pick always passes.
                    if (pick_onehot == prev_onehot) begin
                        state  <= REQ;
                        change <= 1'b1;
                    end else begin
                        prev_onehot <= pick_onehot;
                        target      <= pick_onehot;
                        timer       <= '0;
                        state       <= SHOW;
                    end
`else
                    target <= pick_onehot;
                    timer  <= '0;
                    state  <= SHOW;
`endif
                end
                SHOW: begin
                    if ((hit_sw & target) != '0) begin
                        hit_pulse <= 1'b1;
                        target    <= '0;
                        round_cnt <= round_cnt + 8'd1;
                        state     <= DONE;
                    end else if (timer == TMR_LAST) begin
                        miss_pulse <= 1'b1;
                        target     <= '0;
                        round_cnt  <= round_cnt + 8'd1;
                        state      <= DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state  <= REQ;
                        change <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/target_picker.md
TARGET_PICKER -- requirements
Module: target_picker

Interface
REQ-001 SHALL have parameter RNG_WAIT, default 2, meaning cycles waited after a change pulse before sampling random_value (minimum 1).
REQ-002 SHALL have parameter TIMEOUT, default 50_000_000, meaning cycles a target stays lit before a miss (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; while high, rounds run back-to-back.
REQ-006 SHALL have port random_value  input  18  value from the RNG counter.
REQ-007 SHALL have port hit_sw  input  18  player switches, already synchronised, level.
REQ-008 SHALL have port change  output  1  one-cycle request pulse to the RNG counter.
REQ-009 SHALL have port target  output  18  one-hot lit target, zero when no target is shown.
REQ-010 SHALL have port hit_pulse  output  1  one-cycle pulse on a successful hit.
REQ-011 SHALL have port miss_pulse  output  1  one-cycle pulse on a timeout.
REQ-012 SHALL have port round_cnt  output  8  completed rounds, wraps 255->0.

Function
REQ-013 SHALL implement states IDLE, REQ, WAIT, PICK, SHOW, DONE.
REQ-014 IDLE: start=1 -> REQ next cycle; otherwise stay in IDLE with target=0.
REQ-015 REQ: change=1 for exactly this cycle; -> WAIT.
REQ-016 WAIT: count RNG_WAIT cycles, then -> PICK; change=0 throughout.
REQ-017 PICK: idx = random_value[4:0] if <18, else random_value[4:0]-18; register target = 1<<idx; -> SHOW.
REQ-018 SHOW: timer counts from 0 each cycle; if (hit_sw & target)!=0, pulse hit_pulse and go to DONE; else if timer==TIMEOUT-1, pulse miss_pulse and go to DONE.
REQ-019 A hit and the timeout occurring in the same cycle SHALL count as a hit only.
REQ-020 hit_sw bits outside target SHALL be ignored (no penalty).
REQ-021 DONE: target=0, round_cnt+1 (mod 256); -> REQ if start=1, else IDLE.
REQ-022 start falling during REQ/WAIT/PICK/SHOW SHALL NOT abort the round; it only takes effect in DONE.
REQ-023 hit_pulse and miss_pulse SHALL be mutually exclusive and SHALL occur at most once per round.
REQ-024 Latency: start rise to target nonzero = RNG_WAIT+2 cycles.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, change=0, target=0, hit_pulse=0, miss_pulse=0, round_cnt=0, and clear timers, independent of clk.
REQ-027 Reset asserted mid-round SHALL discard the round without a hit or miss pulse; after release, wait in IDLE for start.

Configuration
REQ-028 With NO_REPEAT_EN defined, a PICK index equal to the previous round's index SHALL be rejected and the FSM SHALL return to REQ (new change pulse), with no retry limit; the previous index clears on reset.
REQ-029 Without NO_REPEAT_EN, repeated indices SHALL be accepted and no previous-index register SHALL exist.

Structure
REQ-030 State encoding enum, NUM_TARGETS=18, and IDX_W=5 SHALL live in shared package game_pkg.
REQ-031 The index fold and one-hot decode SHALL be a sub-module target_decode (combinational, random_value[4:0] in, 18-bit one-hot out).
REQ-032 No other sub-modules; the timeout counter width SHALL be $clog2(TIMEOUT).

Verification (RNG_WAIT=2, TIMEOUT=8 in bench)
REQ-033 Reset, then start=1 with random_value=5 -> change high in cycle 1 only; target=18'h00020 in cycle 4.
REQ-034 random_value[4:0]=20 -> target bit 2; random_value[4:0]=17 -> bit 17; random_value[4:0]=31 -> bit 13.
REQ-035 Target bit 3 lit; hit_sw=18'h00008 on the 3rd SHOW cycle -> hit_pulse for 1 cycle, target=0, round_cnt=1.
REQ-036 No hit_sw for 8 SHOW cycles -> miss_pulse once; hit_sw=18'h00001 with target bit 3 -> no pulse; hit on the 8th cycle -> hit only.
REQ-037 Assert reset during SHOW -> target=0 and round_cnt=0 asynchronously, no pulses; start=0 mid-round -> round completes, then IDLE.
REQ-038 NO_REPEAT_EN: random_value=5, 5, 6 across requests -> second round emits two change pulses; target bit 6.
